sta_sched: RTL and testbench

STA_SCHED -- requirements
Module: sta_sched

---
 rtl/sta_sched.sv | 146 ++++++++++++++
 tb/tb_sta_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sta_sched.sv
// Two-client round-robin scheduler in front of an STA engine: grants one client,
// forwards NBEAT beats to the engine, then relays the engine's results back.
module sta_sched #(
    parameter int unsigned NBEAT   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic        req_b,
    output logic        gnt_a,
    output logic        gnt_b,
    input  logic        vld_a,
    input  logic        vld_b,
    input  logic [11:0] din_a,
    input  logic [11:0] din_b,
    output logic        eng_in_valid,
    output logic [3:0]  eng_delay,
    output logic [3:0]  eng_source,
    output logic [3:0]  eng_destination,
    input  logic        eng_out_valid,
    input  logic [7:0]  eng_worst_delay,
    input  logic [3:0]  eng_path,
    output logic        res_valid,
    output logic        res_id,
    output logic [7:0]  res_worst_delay,
    output logic [3:0]  res_path,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [2:0] {StIdle, StGrant, StLoad, StWait, StDrain, StGap} state_t;

    localparam logic [5:0]  LastBeat = 6'(NBEAT - 1);
    localparam logic [10:0] LastWait = 11'(TIMEOUT - 1);

    state_t      state;
    logic        ptr;
    logic        served;
    logic        armed;
    logic [5:0]  beat_cnt;
    logic [10:0] wd_cnt;

    logic        win;
    logic        beat_ok;
    logic [11:0] beat_din;

    always_comb begin
        // Lone requester wins; on a tie the pointer decides (0 = A, 1 = B).
        win      = req_b & (~req_a | ptr);
        beat_ok  = served ? vld_b : vld_a;
        beat_din = served ? din_b : din_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            ptr             <= 1'b0;
            served          <= 1'b0;
            armed           <= 1'b0;
            beat_cnt        <= 6'd0;
            wd_cnt          <= 11'd0;
            gnt_a           <= 1'b0;
            gnt_b           <= 1'b0;
            eng_in_valid    <= 1'b0;
            eng_delay       <= 4'd0;
            eng_source      <= 4'd0;
            eng_destination <= 4'd0;
            res_valid       <= 1'b0;
            res_id          <= 1'b0;
            res_worst_delay <= 8'd0;
            res_path        <= 4'd0;
            busy            <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            // Holds off the first grant until the second edge after reset release.
            armed           <= 1'b1;
            eng_in_valid    <= 1'b0;
            eng_delay       <= 4'd0;
            eng_source      <= 4'd0;
            eng_destination <= 4'd0;
            res_valid       <= 1'b0;
            res_worst_delay <= 8'd0;
            res_path        <= 4'd0;
            timeout         <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (armed && (req_a || req_b)) begin
                        served   <= win;
                        res_id   <= win;
                        gnt_a    <= ~win;
                        gnt_b    <= win;
                        busy     <= 1'b1;
                        beat_cnt <= 6'd0;
                        state    <= StGrant;
                    end
                end
                StGrant, StLoad: begin
                    if (beat_ok) begin
                        eng_in_valid <= 1'b1;
                        {eng_delay, eng_source, eng_destination} <= beat_din;
                        if (beat_cnt == LastBeat) begin
                            beat_cnt <= 6'd0;
                            wd_cnt   <= 11'd0;
                            gnt_a    <= 1'b0;
                            gnt_b    <= 1'b0;
                            state    <= StWait;
                        end else begin
                            beat_cnt <= beat_cnt + 6'd1;
                            state    <= StLoad;
                        end
                    end
                end
                StWait: begin
                    res_valid       <= eng_out_valid;
                    res_worst_delay <= eng_worst_delay;
                    res_path        <= eng_path;
                    if (eng_out_valid) begin
                        state <= StDrain;
                    end else if (wd_cnt == LastWait) begin
                        res_valid       <= 1'b1;
                        res_worst_delay <= 8'hFF;
                        res_path        <= 4'd0;
                        timeout         <= 1'b1;
                        state           <= StGap;
                    end else begin
                        wd_cnt <= wd_cnt + 11'd1;
                    end
                end
                StDrain: begin
                    res_valid       <= eng_out_valid;
                    res_worst_delay <= eng_worst_delay;
                    res_path        <= eng_path;
                    if (!eng_out_valid) state <= StGap;
                end
                StGap: begin
                    ptr   <= ~served;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sta_sched.sv
// Directed bench for sta_sched: a job-level reference model checked every cycle,
// plus hand-computed scenario expectations evaluated at the end of the run.
module tb_sta_sched;

    localparam int NBEAT = 32;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, vld_a = 1'b0, vld_b = 1'b0;
    logic [11:0] din_a = '0, din_b = '0;
    logic        eng_out_valid = 1'b0;
    logic [7:0]  eng_worst_delay = '0;
    logic [3:0]  eng_path = '0;
    logic        gnt_a, gnt_b, eng_in_valid, res_valid, res_id, busy, timeout;
    logic [3:0]  eng_delay, eng_source, eng_destination, res_path;
    logic [7:0]  res_worst_delay;

    always #5 clk = ~clk;

    sta_sched #(.NBEAT(NBEAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .vld_a(vld_a), .vld_b(vld_b),
        .din_a(din_a), .din_b(din_b), .eng_in_valid(eng_in_valid),
        .eng_delay(eng_delay), .eng_source(eng_source), .eng_destination(eng_destination),
        .eng_out_valid(eng_out_valid), .eng_worst_delay(eng_worst_delay), .eng_path(eng_path),
        .res_valid(res_valid), .res_id(res_id), .res_worst_delay(res_worst_delay),
        .res_path(res_path), .busy(busy), .timeout(timeout)
    );

    // ---------------- reference model (job-level) ----------------
    int          m_owner, m_taken, m_age, m_since;
    bit          m_result, m_gap, m_ptr;
    logic        e_gnt_a, e_gnt_b, e_eiv, e_res_valid, e_res_id, e_busy, e_tmo;
    logic [11:0] e_eng;
    logic [7:0]  e_rd;
    logic [3:0]  e_rp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_taken = 0; m_age = 0; m_since = 0;
            m_result = 0; m_gap = 0; m_ptr = 0;
            e_gnt_a = 0; e_gnt_b = 0; e_eiv = 0; e_res_valid = 0; e_res_id = 0;
            e_busy = 0; e_tmo = 0; e_eng = '0; e_rd = '0; e_rp = '0;
        end else begin
            e_eiv = 0; e_eng = '0; e_res_valid = 0; e_rd = '0; e_rp = '0; e_tmo = 0;
            if (m_gap) begin
                m_gap   = 0;
                m_ptr   = (m_owner == 0);
                m_owner = -1;
            end else if (m_owner < 0) begin
                if (m_since > 0 && (req_a || req_b)) begin
                    m_owner  = (req_a && req_b) ? int'(m_ptr) : (req_b ? 1 : 0);
                    m_taken  = 0; m_result = 0; m_age = 0;
                    e_res_id = (m_owner == 1);
                end
            end else if (m_taken < NBEAT) begin
                if (m_owner == 0 ? vld_a : vld_b) begin
                    e_eiv = 1;
                    e_eng = (m_owner == 0) ? din_a : din_b;
                    m_taken++;
                end
            end else begin
                e_res_valid = eng_out_valid; e_rd = eng_worst_delay; e_rp = eng_path;
                if (m_result) begin
                    if (!eng_out_valid) m_gap = 1;
                end else if (eng_out_valid) begin
                    m_result = 1;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin
                        e_res_valid = 1; e_rd = 8'hFF; e_rp = '0; e_tmo = 1; m_gap = 1;
                    end
                end
            end
            if (m_since < 2) m_since++;
            e_busy  = (m_owner >= 0);
            e_gnt_a = (m_owner == 0) && (m_taken < NBEAT);
            e_gnt_b = (m_owner == 1) && (m_taken < NBEAT);
        end
    end

    // ---------------- stimulus-side measurements ----------------
    logic [30:0] meas_rst, s34_o;
    logic        g1, g2, b_id, s30_id;
    logic [1:0]  s34_g;
    logic [11:0] s30_pp;
    logic [7:0]  s30_d0, s33_d;
    int          gap_diff, s30_g, s30_e, s30_r, s32_e, s32_m, s33_w, s33_b, s34_r;
    int          wait_fail = 0;
    bit          done = 0;
    logic [11:0] sent [NBEAT];
    logic [3:0]  eng_p [3];
    logic [7:0]  eng_d [3];

    // ---------------- compare / monitor ----------------
    int          n_checks = 0, n_fail = 0, cyc = 0;
    int          n_gnt_a = 0, n_eiv = 0, n_res = 0;
    int          busy_fall = 0, gnt_b_rise = 0, gnt_a_fall = 0, tmo_cyc = 0;
    logic        p_busy = 0, p_gnt_a = 0, p_gnt_b = 0;
    logic [11:0] eiv_log [512];
    logic [3:0]  res_p [512];
    logic [7:0]  res_d [512];
    logic        res_i [512];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        chk("gnt_a", 32'(gnt_a), 32'(e_gnt_a));
        chk("gnt_b", 32'(gnt_b), 32'(e_gnt_b));
        chk("eng_in_valid", 32'(eng_in_valid), 32'(e_eiv));
        chk("eng_data", 32'({eng_delay, eng_source, eng_destination}), 32'(e_eng));
        chk("res_valid", 32'(res_valid), 32'(e_res_valid));
        chk("res_id", 32'(res_id), 32'(e_res_id));
        chk("res_data", 32'({res_worst_delay, res_path}), 32'({e_rd, e_rp}));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("timeout", 32'(timeout), 32'(e_tmo));
        if (gnt_a) n_gnt_a++;
        if (eng_in_valid && n_eiv < 512) begin
            eiv_log[n_eiv] = {eng_delay, eng_source, eng_destination};
            n_eiv++;
        end
        if (res_valid && n_res < 512) begin
            res_p[n_res] = res_path; res_d[n_res] = res_worst_delay; res_i[n_res] = res_id;
            n_res++;
        end
        if (p_busy && !busy) busy_fall = cyc;
        if (!p_gnt_b && gnt_b) gnt_b_rise = cyc;
        if (p_gnt_a && !gnt_a) gnt_a_fall = cyc;
        if (timeout) tmo_cyc = cyc;
        p_busy = busy; p_gnt_a = gnt_a; p_gnt_b = gnt_b;
        if (done || cyc > 20000) begin
            chk("run_completed", 32'(done), 32'd1);
            chk("reset_outputs", 32'(meas_rst), 32'd0);
            chk("grant_edge1", 32'(g1), 32'd0);
            chk("grant_edge2", 32'(g2), 32'd1);
            chk("b_grant_after_gap", 32'(gap_diff), 32'd1);
            chk("b_res_id", 32'(b_id), 32'd1);
            chk("a_gnt_cycles", 32'(s30_g), 32'd33);
            chk("a_eiv_count", 32'(s30_e), 32'd32);
            chk("a_res_count", 32'(s30_r), 32'd3);
            chk("a_res_paths", 32'(s30_pp), 32'h041);
            chk("a_res_delay", 32'(s30_d0), 32'd23);
            chk("a_res_id", 32'(s30_id), 32'd0);
            chk("filter_eiv_count", 32'(s32_e), 32'd32);
            chk("filter_data", 32'(s32_m), 32'd32);
            chk("wd_wait_cycles", 32'(s33_w), 32'd16);
            chk("wd_busy_drop", 32'(s33_b), 32'd1);
            chk("wd_res_delay", 32'(s33_d), 32'hFF);
            chk("abort_outputs", 32'(s34_o), 32'd0);
            chk("abort_no_result", 32'(s34_r), 32'd0);
            chk("abort_regrant", 32'(s34_g), 32'd2);
            chk("stim_waits", 32'(wait_fail), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [30:0] outs();
        return {gnt_a, gnt_b, eng_in_valid, eng_delay, eng_source, eng_destination,
                res_valid, res_id, res_worst_delay, res_path, busy, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit c, input int nb, input bit gaps, input bit noise);
        int w = 0;
        logic [11:0] v;
        while (!(c ? gnt_b : gnt_a) && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) wait_fail++;
        if (c) req_b = 0; else req_a = 0;
        tick();  // client reacts to the grant one cycle later
        for (int i = 0; i < nb; i++) begin
            v = 12'(i * 149 + 53 * int'(c) + 7);
            if (c) begin vld_b = 1; din_b = v; end
            else begin vld_a = 1; din_a = v; sent[i] = v; end
            if (noise) begin vld_b = 1; din_b = ~v; end
            tick();
            if (gaps) begin
                vld_a = 0;
                if (!noise) vld_b = 0;
                tick();
            end
        end
        vld_a = 0; vld_b = 0; din_a = '0; din_b = '0;
    endtask

    task automatic engine(input int n, input int lead);
        repeat (lead) tick();
        for (int i = 0; i < n; i++) begin
            eng_out_valid = 1; eng_path = eng_p[i]; eng_worst_delay = eng_d[i];
            tick();
        end
        eng_out_valid = 0; eng_path = '0; eng_worst_delay = '0;
        repeat (4) tick();
    endtask

    initial begin
        int bg, be, br;
        eng_p[0] = 4'd0; eng_p[1] = 4'd4; eng_p[2] = 4'd1;
        eng_d[0] = 8'd23; eng_d[1] = 8'd17; eng_d[2] = 8'd9;

        // Both clients requesting out of reset: A first, then B.
        #1 rst_n = 0; req_a = 1; req_b = 1;
        repeat (3) tick();
        meas_rst = outs();
        rst_n = 1;
        tick(); g1 = gnt_a;
        tick(); g2 = gnt_a;
        load(0, NBEAT, 0, 0);
        engine(3, 2);
        load(1, NBEAT, 0, 0);
        gap_diff = gnt_b_rise - busy_fall;
        br = n_res;
        engine(3, 2);
        b_id = res_i[br];

        // Stray engine result while idle, then a plain A job.
        eng_out_valid = 1; eng_path = 4'd7; eng_worst_delay = 8'd99;
        tick();
        eng_out_valid = 0; eng_path = '0; eng_worst_delay = '0;
        tick();
        bg = n_gnt_a; be = n_eiv; br = n_res;
        req_a = 1;
        load(0, NBEAT, 0, 0);
        engine(3, 2);
        s30_g = n_gnt_a - bg; s30_e = n_eiv - be; s30_r = n_res - br;
        s30_pp = {res_p[br], res_p[br + 1], res_p[br + 2]};
        s30_d0 = res_d[br]; s30_id = res_i[br];

        // Gappy A beats while B spams valid beats.
        be = n_eiv;
        vld_b = 1; din_b = 12'hABC; req_a = 1;
        load(0, NBEAT, 1, 1);
        s32_e = n_eiv - be;
        s32_m = 0;
        for (int i = 0; i < NBEAT; i++) if (eiv_log[be + i] == sent[i]) s32_m++;
        engine(3, 2);

        // Silent engine: watchdog fires.
        req_a = 1;
        load(0, NBEAT, 0, 0);
        repeat (25) tick();
        s33_w = tmo_cyc - gnt_a_fall;
        s33_b = busy_fall - tmo_cyc;
        s33_d = res_d[n_res - 1];

        // Reset in the middle of a load.
        req_a = 1;
        load(0, 20, 0, 0);
        rst_n = 0;
        #1 s34_o = outs();
        br = n_res;
        repeat (2) tick();
        rst_n = 1; req_a = 1; req_b = 1;
        tick(); tick();
        s34_g = {gnt_a, gnt_b};
        s34_r = n_res - br;
        req_a = 0; req_b = 0;
        tick();
        done = 1;
    end

endmodule
